sipo_deser: RTL and testbench
=============================

SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 4, data word width in bits (legal range 2..16).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clr  input  1  reset, asynchronous, active-high; clears all state.
REQ-004 si  input  1  serial data in, MSB first; the PISO `so` output drives it.
REQ-005 en  input  1  shift enable; si is sampled on a rising clk edge only when en=1.
REQ-006 po  output  WIDTH  assembled parallel word, registered.
REQ-007 po_valid  output  1  po holds an unconsumed word.
REQ-008 po_ready  input  1  consumer accepts po in any cycle where po_valid=1 and po_ready=1.
REQ-009 busy  output  1  high while a partial word is held (bit count nonzero).
REQ-010 ovr  output  1  sticky overrun flag.
REQ-011 perr  output  1  parity error flag for the current po word (see Configuration).

Function
REQ-012 State: shift register sr[WIDTH-1:0], bit counter cnt (0..FRAME-1), output register po, flags po_valid, ovr, perr; FRAME=WIDTH (or WIDTH+1 with parity).
REQ-013 The block shall have exactly two states: IDLE (cnt=0) and COLLECT (cnt>0); busy = (cnt!=0).
REQ-014 On an edge with en=1: sr <= {sr[WIDTH-2:0], si}; cnt increments; with en=0, sr and cnt hold.
REQ-015 On the edge that samples the last frame bit, cnt shall wrap to 0 and the word is complete; the next sampled bit starts a new word with no idle cycle required.
REQ-016 On completion with po_valid=0, or with po_valid=1 and po_ready=1 on the same edge, po shall load the completed word and po_valid shall be 1 after that edge (latency: valid one edge after the last bit, no extra cycle).
REQ-017 On completion with po_valid=1 and po_ready=0, the new word shall be discarded, po and po_valid shall hold, and ovr shall set to 1.
REQ-018 With po_valid=1, po_ready=1 and no completion, po_valid shall clear on that edge; po shall keep its last value.
REQ-019 ovr shall stay set until clr; it shall not affect shifting.
REQ-020 po_ready while po_valid=0 shall have no effect.
REQ-021 en deasserted mid-word shall pause collection; the partial word shall be kept indefinitely.

Reset
REQ-022 clr=1 shall immediately force sr=0, cnt=0, po=0, po_valid=0, busy=0, ovr=0, perr=0, regardless of clk.
REQ-023 clr asserted mid-word shall discard the partial word; the first en=1 edge after release shall sample the MSB of a new word.

Configuration
REQ-024 Macro SIPO_DESER_PARITY_EN: when defined, FRAME=WIDTH+1; the bit after the data LSB is an even-parity bit over the data.
REQ-025 With SIPO_DESER_PARITY_EN, perr shall load together with po: 1 if XOR(data bits, parity bit)=1, else 0. On discard (REQ-017), perr shall hold.
REQ-026 Without SIPO_DESER_PARITY_EN, FRAME=WIDTH and perr shall be constant 0.

Verification
REQ-027 clr pulse, then en=1 for 4 edges with si=1,1,1,0 and po_ready=0 -> after 4th edge po=4'b1110, po_valid=1, busy=0, ovr=0.
REQ-028 Continue: po_ready=1 for one edge, then shift 0,1,1,0 -> po_valid drops after accept; after 4th bit po=4'b0110, po_valid=1.
REQ-029 With po_valid=1, po_ready=0, shift 4 more bits 1,0,1,0 -> po stays 4'b0110, ovr=1; a later accept leaves ovr=1.
REQ-030 Shift 2 bits, assert clr for 3 ns between edges -> busy=0, cnt=0 at once; next 4 bits 1,0,0,1 give po=4'b1001.
REQ-031 Shift 1,0, en=0 for 5 cycles, then 1,1 -> po=4'b1011 and busy=1 throughout the pause; completion on the same edge as po_ready=1 with old word -> po_valid stays 1, ovr=0.
REQ-032 Built with SIPO_DESER_PARITY_EN: frame 1,1,1,0,1 -> po=4'b1110, perr=0; frame 1,1,1,0,0 -> perr=1.

Source files
------------

// File: rtl/sipo_deser.sv
// -----------------------------------------------------------------------------
// sipo_deser -- serial-in / parallel-out deserializer, MSB first.
//
// Collects a frame of serial bits from `si` (sampled only on rising clk edges
// where en=1) and presents each completed word on `po`. Consumption follows
// the po_valid/po_ready rule described at the port list below.
//
// Optional feature, selected by the macro SIPO_DESER_PARITY_EN:
//   undefined (default) : frame = WIDTH data bits, perr is constant 0.
//   defined             : frame = WIDTH data bits + 1 even-parity bit, and
//                         perr flags a parity mismatch for the word on po.
//
// Ports:
//   clk       in   rising-edge clock for all state
//   clr       in   asynchronous active-high clear of all state
//   si        in   serial data in, MSB first
//   en        in   shift enable; si sampled only when en=1
//   po        out  [WIDTH-1:0] assembled parallel word (registered)
//   po_valid  out  po holds an unconsumed word
//   po_ready  in   consumer accepts po
//   busy      out  a partial word is held (bit count nonzero)
//   ovr       out  sticky overrun: a completed word was dropped
//   perr      out  parity error flag for the word on po
//   fsm_state out  current FSM state (0 = IDLE, 1 = COLLECT) for observation
// -----------------------------------------------------------------------------
module sipo_deser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             si,
  input  logic             en,
  // Handshake: a word transfers on any rising edge where po_valid=1 and
  // po_ready=1. po_valid never drops without a transfer, po is stable while
  // po_valid=1, and po_ready while po_valid=0 is ignored.
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             busy,
  output logic             ovr,
  output logic             perr,
  output logic             fsm_state
);

`ifdef SIPO_DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;

  logic             last_bit;
  logic             data_shift;
  logic [WIDTH-1:0] word;
  logic             par_err;

  assign last_bit = en && (cnt == LAST);

  always_comb begin
    word       = '0;
    par_err    = 1'b0;
    data_shift = 1'b0;
`ifdef SIPO_DESER_PARITY_EN
    // The parity bit is not shifted into the data register; the data bits
    // are already complete in sr when it arrives.
    word       = sr;
    par_err    = ^{sr, si};
    data_shift = en && !last_bit;
`else
    // The completed word includes the bit being sampled on this edge.
    word       = {sr[WIDTH-2:0], si};
    par_err    = 1'b0;
    data_shift = en;
`endif
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      cnt      <= '0;
      sr       <= '0;
      po       <= '0;
      po_valid <= 1'b0;
      ovr      <= 1'b0;
      perr     <= 1'b0;
    end else begin
      if (data_shift) begin
        sr <= {sr[WIDTH-2:0], si};
      end

      if (en) begin
        if (last_bit) begin
          cnt   <= '0;
          state <= IDLE;
        end else begin
          cnt   <= cnt + 1'b1;
          state <= COLLECT;
        end
      end

      if (last_bit) begin
        // A word completing while the previous one is still unconsumed is
        // dropped; po, po_valid and perr keep describing the old word.
        if (!po_valid || po_ready) begin
          po       <= word;
          po_valid <= 1'b1;
          perr     <= par_err;
        end else begin
          ovr <= 1'b1;
        end
      end else if (po_valid && po_ready) begin
        po_valid <= 1'b0;
      end
    end
  end

  assign busy      = (state == COLLECT);
  assign fsm_state = state;

endmodule

// File: tb/tb_sipo_deser.sv
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       si = 1'b0;
  logic       en = 1'b0;
  logic       po_ready = 1'b0;
  logic [3:0] po;
  logic       po_valid;
  logic       busy;
  logic       ovr;
  logic       perr;
  logic       fsm_state;

  int checks = 0;
  int errors = 0;

  sipo_deser #(.WIDTH(4)) dut (
    .clk      (clk),
    .clr      (clr),
    .si       (si),
    .en       (en),
    .po       (po),
    .po_valid (po_valid),
    .po_ready (po_ready),
    .busy     (busy),
    .ovr      (ovr),
    .perr     (perr),
    .fsm_state(fsm_state)
  );

  // Clock / reset: rising edges at 5, 15, 25 ...; stimulus on falling edges.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle from a falling edge; return at the next falling edge.
  task automatic step(input logic e, input logic s, input logic r);
    en       = e;
    si       = s;
    po_ready = r;
    @(posedge clk);
    @(negedge clk);
    en       = 1'b0;
    po_ready = 1'b0;
  endtask

  task automatic clr_pulse();
    #1 clr = 1'b1;
    #1;
    chk("clr_busy", {31'd0, busy}, 32'd0);
    chk("clr_state", {31'd0, fsm_state}, 32'd0);
    chk("clr_po", {28'd0, po}, 32'd0);
    chk("clr_valid", {31'd0, po_valid}, 32'd0);
    chk("clr_ovr", {31'd0, ovr}, 32'd0);
    chk("clr_perr", {31'd0, perr}, 32'd0);
    #2 clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state at power-up, before any clock edge.
    clr_pulse();

`ifdef SIPO_DESER_PARITY_EN
    // Good frame 1110 + parity 1.
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
    chk("p_busy4", {31'd0, busy}, 32'd1);
    chk("p_valid4", {31'd0, po_valid}, 32'd0);
    step(1, 1, 0);
    chk("p1_po", {28'd0, po}, 32'he);
    chk("p1_valid", {31'd0, po_valid}, 32'd1);
    chk("p1_perr", {31'd0, perr}, 32'd0);
    chk("p1_busy", {31'd0, busy}, 32'd0);
    step(0, 0, 1);
    chk("p1_acc", {31'd0, po_valid}, 32'd0);
    // Bad parity frame 1110 + 0.
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0); step(1, 0, 0); step(1, 0, 0);
    chk("p2_po", {28'd0, po}, 32'he);
    chk("p2_perr", {31'd0, perr}, 32'd1);
    // Good frame 0011 + 0 while unconsumed: dropped, perr holds.
    step(1, 0, 0); step(1, 0, 0); step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
    chk("p3_po", {28'd0, po}, 32'he);
    chk("p3_perr", {31'd0, perr}, 32'd1);
    chk("p3_ovr", {31'd0, ovr}, 32'd1);
`else
    // First word 1110, no consumer.
    step(1, 1, 0);
    chk("w1_busy1", {31'd0, busy}, 32'd1);
    chk("w1_state1", {31'd0, fsm_state}, 32'd1);
    step(1, 1, 0); step(1, 1, 0);
    chk("w1_valid3", {31'd0, po_valid}, 32'd0);
    step(1, 0, 0);
    chk("w1_po", {28'd0, po}, 32'he);
    chk("w1_valid", {31'd0, po_valid}, 32'd1);
    chk("w1_busy", {31'd0, busy}, 32'd0);
    chk("w1_ovr", {31'd0, ovr}, 32'd0);
    chk("w1_perr", {31'd0, perr}, 32'd0);

    // Accept, then second word 0110.
    step(0, 0, 1);
    chk("w1_acc_valid", {31'd0, po_valid}, 32'd0);
    chk("w1_acc_po", {28'd0, po}, 32'he);
    step(1, 0, 0); step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
    chk("w2_po", {28'd0, po}, 32'h6);
    chk("w2_valid", {31'd0, po_valid}, 32'd1);

    // Back-to-back word 1010 while unconsumed: dropped, overrun.
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 0, 0);
    chk("w3_po", {28'd0, po}, 32'h6);
    chk("w3_valid", {31'd0, po_valid}, 32'd1);
    chk("w3_ovr", {31'd0, ovr}, 32'd1);
    step(0, 0, 1);
    chk("w3_acc_valid", {31'd0, po_valid}, 32'd0);
    chk("w3_acc_ovr", {31'd0, ovr}, 32'd1);

    // Partial word discarded by clr, then 1001.
    step(1, 1, 0); step(1, 1, 0);
    chk("w4_busy2", {31'd0, busy}, 32'd1);
    clr_pulse();
    step(1, 1, 0); step(1, 0, 0); step(1, 0, 0); step(1, 1, 0);
    chk("w4_po", {28'd0, po}, 32'h9);
    chk("w4_valid", {31'd0, po_valid}, 32'd1);

    // 1,0 then a 5-cycle pause, then 1,1 with accept on the completing edge.
    step(1, 1, 0); step(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0);
      chk("w5_pause_busy", {31'd0, busy}, 32'd1);
    end
    chk("w5_pause_po", {28'd0, po}, 32'h9);
    step(1, 1, 0);
    step(1, 1, 1);
    chk("w5_po", {28'd0, po}, 32'hb);
    chk("w5_valid", {31'd0, po_valid}, 32'd1);
    chk("w5_ovr", {31'd0, ovr}, 32'd0);
    chk("w5_busy", {31'd0, busy}, 32'd0);

    // Accept, then po_ready with nothing valid has no effect.
    step(0, 0, 1);
    chk("w5_acc_valid", {31'd0, po_valid}, 32'd0);
    step(0, 0, 1);
    chk("idle_rdy_valid", {31'd0, po_valid}, 32'd0);
    chk("idle_rdy_po", {28'd0, po}, 32'hb);
    chk("idle_rdy_busy", {31'd0, busy}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
